shift_seq: RTL and testbench
============================

Name: shift_seq

Overview:
Parametrised sequential shift/rotate unit for the model-machine datapath. It is the successor of the combinational single-bit shifter. It performs multi-bit shifts one bit per clock, supports eight modes including arithmetic shifts and rotate-through-carry, and uses a start/busy/done handshake. The result drives the internal bus through a tri-state output under control of out_en, so it can share the bus with other sources.

Parameters:
WIDTH, 8, data width in bits (>=2)
AMT_W, $clog2(WIDTH)+1, width of shift-amount input (amounts 0..2^AMT_W-1 legal)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active low
start  input  1  request; sampled when state is IDLE or DONE
mode  input  3  operation select, latched on accepted start
amt  input  AMT_W  shift count, latched on accepted start
a  input  WIDTH  operand, latched on accepted start
cin  input  1  carry in, latched on accepted start
out_en  input  1  bus drive enable for w
w  output  WIDTH  result when out_en=1, else all high-Z
cf  output  1  carry flag, registered
zf  output  1  zero flag (result==0), registered
busy  output  1  high while state is SHIFT
done  output  1  one-cycle pulse, high while state is DONE

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, result=0, cf=0, zf=1, busy=0, done=0, counter=0. w is high-Z unless out_en=1, in which case it drives 0.
- Modes:
  - 000 PASS
  - 001 ROL
  - 010 ROR
  - 011 SHL: logical; 0 enters at LSB; cf=bit out
  - 100 SHR: logical; 0 enters at MSB; cf=bit out
  - 101 SAR: MSB replicated; cf=bit out
  - 110 RCL: WIDTH+1 rotate through cf
  - 111 RCR: WIDTH+1 rotate through cf
- For ROL/ROR, each step sets cf to the bit that wrapped.
- States:
  - IDLE/DONE, start=1: latch a->result, cin->cf, amt->counter.
    - PASS, or amt==0: go to DONE. cf=0 for PASS; cf=cin for any mode with amt==0.
    - Otherwise go to SHIFT.
  - IDLE/DONE, start=0: DONE->IDLE, IDLE holds. Result and flags hold.
  - SHIFT: each rising edge applies one single-bit step to {cf,result} and decrements counter. The edge where counter goes 1->0 also moves to DONE. start is ignored in SHIFT; there is no queueing.
- Latency: start accepted at edge T0 gives done=1 in the cycle after edge T0+amt, or after T0 itself for PASS/amt==0.
- Back-to-back: start during DONE is accepted, so done pulses are never stretched.
- zf is updated together with result on every write, including the load.
- w is combinational from result and out_en. cf and zf are always driven, never Z.
- No width growth: amounts >= WIDTH simply iterate. SHL/SHR reach 0, SAR reaches all-sign, rotates wrap modulo WIDTH (or WIDTH+1 for RCL/RCR).
- Reset mid-SHIFT aborts immediately to the reset values. No done pulse is produced.
- X on mode/amt/a is don't-care unless the start is accepted.

Decomposition:
- Package shift_pkg holds:
  - mode localparams: MODE_PASS, MODE_ROL, MODE_ROR, MODE_SHL, MODE_SHR, MODE_SAR, MODE_RCL, MODE_RCR
  - state encoding: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
- One combinational sub-module, shift_step (parameter WIDTH):
  - inputs: mode, value, cin
  - outputs: next value, next carry
  - performs exactly one single-bit step
  - reused by the FSM and by the bench's reference model.

Test Plan:
- Reset, then out_en=0 -> w=ZZ; out_en=1 -> w=0x00, cf=0, zf=1, busy=0, done=0.
- ROL, a=0x81, amt=1, cin=0 -> busy for 1 cycle, done pulse; w=0x03, cf=1, zf=0.
- SAR, a=0x90, amt=3 -> done after 3 shift cycles; w=0xF2, cf=0.
- RCR, a=0x01, cin=0, amt=2 -> w=0x80, cf=0. Also SHL, a=0xFF, amt=8 -> w=0x00, cf=1, zf=1, done 8 cycles after start.
- Second start pulsed mid-SHIFT is ignored, result unchanged. PASS a=0x5A -> done next cycle, w=0x5A, cf=0. Back-to-back start in DONE is accepted.
- rst_n low for 1 cycle mid-SHIFT (amt=5, cycle 2) -> state IDLE, no done, result=0, zf=1. A new start then completes normally.

Source files
------------

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - mode codes and FSM state encoding for the sequential shifter
package shift_pkg;

    localparam logic [2:0] MODE_PASS = 3'd0;
    localparam logic [2:0] MODE_ROL  = 3'd1;
    localparam logic [2:0] MODE_ROR  = 3'd2;
    localparam logic [2:0] MODE_SHL  = 3'd3;
    localparam logic [2:0] MODE_SHR  = 3'd4;
    localparam logic [2:0] MODE_SAR  = 3'd5;
    localparam logic [2:0] MODE_RCL  = 3'd6;
    localparam logic [2:0] MODE_RCR  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_seq_if.sv
// rtl/shift_seq_if.sv - request/handshake/flag bundle between the datapath and the shifter
interface shift_seq_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
);
    logic             start;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] a;
    logic             cin;
    logic             out_en;
    logic             cf;
    logic             zf;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, amt, a, cin, out_en,
        input  cf, zf, busy, done
    );

    modport slave (
        input  start, mode, amt, a, cin, out_en,
        output cf, zf, busy, done
    );
endinterface

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one single-bit shift/rotate step on {carry,value}
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] value,
    input  logic             cin,
    output logic [WIDTH-1:0] next_value,
    output logic             next_cin
);

    always_comb begin
        next_value = value;
        next_cin   = cin;
        case (mode)
            MODE_ROL: begin
                next_value = {value[WIDTH-2:0], value[WIDTH-1]};
                next_cin   = value[WIDTH-1];
            end
            MODE_ROR: begin
                next_value = {value[0], value[WIDTH-1:1]};
                next_cin   = value[0];
            end
            MODE_SHL: begin
                next_value = {value[WIDTH-2:0], 1'b0};
                next_cin   = value[WIDTH-1];
            end
            MODE_SHR: begin
                next_value = {1'b0, value[WIDTH-1:1]};
                next_cin   = value[0];
            end
            MODE_SAR: begin
                next_value = {value[WIDTH-1], value[WIDTH-1:1]};
                next_cin   = value[0];
            end
            // Rotate-through-carry: the carry acts as an extra (WIDTH+1)th bit.
            MODE_RCL: begin
                next_value = {value[WIDTH-2:0], cin};
                next_cin   = value[WIDTH-1];
            end
            MODE_RCR: begin
                next_value = {cin, value[WIDTH-1:1]};
                next_cin   = value[0];
            end
            default: begin
                next_value = value;
                next_cin   = cin;
            end
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - multi-cycle shift/rotate unit, one bit per clock, tri-state bus result
module shift_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_seq_if.slave       bus,
    output wire [WIDTH-1:0]  w
);

    state_t           state;
    logic [WIDTH-1:0] result;
    logic [AMT_W-1:0] counter;
    logic [2:0]       mode_r;
    logic             cf_r;
    logic             zf_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] step_value;
    logic             step_cf;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .mode       (mode_r),
        .value      (result),
        .cin        (cf_r),
        .next_value (step_value),
        .next_cin   (step_cf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            result  <= '0;
            counter <= '0;
            mode_r  <= MODE_PASS;
            cf_r    <= 1'b0;
            zf_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    result  <= step_value;
                    cf_r    <= step_cf;
                    zf_r    <= (step_value == '0);
                    counter <= counter - AMT_W'(1);
                    if (counter == AMT_W'(1)) begin
                        state  <= ST_DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request, so done never stretches.
                    if (bus.start) begin
                        result  <= bus.a;
                        zf_r    <= (bus.a == '0);
                        counter <= bus.amt;
                        mode_r  <= bus.mode;
                        if (bus.mode == MODE_PASS || bus.amt == '0) begin
                            cf_r   <= (bus.mode == MODE_PASS) ? 1'b0 : bus.cin;
                            state  <= ST_DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end else begin
                            cf_r   <= bus.cin;
                            state  <= ST_SHIFT;
                            busy_r <= 1'b1;
                            done_r <= 1'b0;
                        end
                    end else begin
                        state  <= ST_IDLE;
                        done_r <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.cf   = cf_r;
    assign bus.zf   = zf_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign w        = bus.out_en ? result : {WIDTH{1'bz}};

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - randomized scoreboard bench for shift_seq
module tb_shift_seq;
    localparam int W  = 8;
    localparam int AW = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    wire  [W-1:0] w;
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        int           lat;
        int           t0;
    } exp_t;

    exp_t q[$];

    shift_seq_if #(.WIDTH(W), .AMT_W(AW)) bus ();

    shift_seq #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .w     (w)
    );

    // Undriven bus reads as all ones.
    for (genvar i = 0; i < W; i++) begin : g_pu
        pullup (w[i]);
    end

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic longint rotl(input longint x, input int k, input int len);
        longint m;
        m = (64'd1 << len) - 1;
        if (k == 0) return x & m;
        return ((x << k) | (x >> (len - k))) & m;
    endfunction

    function automatic exp_t model(input int m, input int n, input logic [W-1:0] a, input logic cin);
        exp_t   e;
        longint v;
        int     k;
        logic [W-1:0] mask;
        mask  = '1;
        e.lat = (m == 0 || n == 0) ? 0 : n;
        e.t0  = 0;
        e.r   = a;
        e.c   = (m == 0) ? 1'b0 : cin;
        if (m != 0 && n != 0) begin
            case (m)
                1: begin e.r = W'(rotl(a, n % W, W)); e.c = e.r[0]; end
                2: begin e.r = W'(rotl(a, (W - n % W) % W, W)); e.c = e.r[W-1]; end
                3: begin
                    e.r = (n >= W) ? '0 : W'(a << n);
                    e.c = (n <= W) ? a[W-n] : 1'b0;
                end
                4: begin
                    e.r = (n >= W) ? '0 : W'(a >> n);
                    e.c = (n <= W) ? a[n-1] : 1'b0;
                end
                5: begin
                    if (n >= W) e.r = a[W-1] ? mask : '0;
                    else        e.r = W'(a >> n) | (a[W-1] ? W'(mask << (W - n)) : '0);
                    e.c = a[((n < W) ? n : W) - 1];
                end
                default: begin
                    v = {55'd0, cin, a};
                    k = n % (W + 1);
                    if (m == 7) k = (W + 1 - k) % (W + 1);
                    v = rotl(v, k, W + 1);
                    e.r = v[W-1:0];
                    e.c = v[W];
                end
            endcase
        end
        e.z = (e.r == '0);
        return e;
    endfunction

    task automatic issue(input int m, input int n, input logic [W-1:0] a, input logic cin, input bit push);
        exp_t e;
        bus.mode  = 3'(m);
        bus.amt   = AW'(n);
        bus.a     = a;
        bus.cin   = cin;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (push) begin
            e    = model(m, n, a, cin);
            e.t0 = cyc;
            q.push_back(e);
        end
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (bus.done) return;
        end
        checks++;
        errors++;
        $display("FAIL done_timeout: no done within %0d cycles", bound);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("w",       w,        e.r);
                    chk("cf",      bus.cf,   e.c);
                    chk("zf",      bus.zf,   e.z);
                    chk("latency", cyc - e.t0, e.lat);
                end
            end
        end
    end

    initial begin
        bus.start  = 1'b0;
        bus.mode   = '0;
        bus.amt    = '0;
        bus.a      = '0;
        bus.cin    = 1'b0;
        bus.out_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_w_z", w, 8'hFF);
        bus.out_en = 1'b1;
        #1;
        chk("reset_w",    w,        8'h00);
        chk("reset_cf",   bus.cf,   0);
        chk("reset_zf",   bus.zf,   1);
        chk("reset_busy", bus.busy, 0);
        chk("reset_done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1, 1, 8'h81, 1'b0, 1);
        chk("rol_busy", bus.busy, 1);
        wait_done(20);
        issue(5, 3, 8'h90, 1'b0, 1);
        wait_done(20);
        issue(7, 2, 8'h01, 1'b0, 1);
        wait_done(20);

        // Start during SHIFT must be ignored.
        issue(3, 8, 8'hFF, 1'b0, 1);
        @(negedge clk);
        issue(0, 0, 8'h5A, 1'b1, 0);
        chk("ignored_start_busy", bus.busy, 1);
        wait_done(20);
        issue(0, 0, 8'h5A, 1'b1, 1);
        wait_done(20);
        issue(0, 9, 8'h00, 1'b1, 1);
        wait_done(20);

        // Reset during SHIFT aborts without a done pulse.
        issue(4, 5, 8'hC3, 1'b1, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_w",    w,        8'h00);
        chk("abort_cf",   bus.cf,   0);
        chk("abort_zf",   bus.zf,   1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        issue(1, 1, 8'h81, 1'b0, 1);
        wait_done(20);

        for (int i = 0; i < 80; i++) begin
            issue($urandom_range(0, 7), $urandom_range(0, 15), W'($urandom), 1'($urandom), 1);
            wait_done(25);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
